ssd_scan_controller: RTL and testbench
======================================

// Module: ssd_scan_controller
// PURPOSE
//   Sequencer for the 4-digit seven-segment display: converts the 13-bit binary display value to BCD
//   with a multi-cycle shift-add-3 FSM, then time-multiplexes the four digits onto Anode/LED_out.
//   Sits between the CPU's SSD value output and the board display pins.
// PARAMETERS
//   REFRESH_DIV   100000   clk cycles each digit stays lit; legal range >= 1
// PORTS
//   clk        in   1    system clock, all state on rising edge
//   rst        in   1    asynchronous reset, active-low (0 = reset)
//   num        in   13   unsigned value to display, 0..8191
//   Anode      out  4    digit enables, active-low; Anode[0] = rightmost (units) digit
//   LED_out    out  7    segments, active-low, {a,b,c,d,e,f,g}
//   busy       out  1    1 while a BCD conversion is in progress
//   bcd_valid  out  1    1 once the first conversion has committed; sticky until reset
// BEHAVIOUR
//   Reset (rst=0, immediate): Anode=4'b1111, LED_out=7'b1111111, busy=0, bcd_valid=0;
//     digit index=0, refresh counter=0, display BCD reg=0, shown_num=0, first flag=1, FSM=IDLE.
//   Converter FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
//     IDLE:   if first flag set or num != shown_num: capture num into shift reg, clear 16-bit BCD
//             scratch and bit counter, busy<=1, go SHIFT. Otherwise stay.
//     SHIFT:  per cycle, every scratch nibble >= 5 gets +3, then {scratch,shift} shifts left 1.
//             Exactly 13 SHIFT cycles (counter 0..12), then go COMMIT.
//     COMMIT: display reg <= scratch, shown_num <= captured value, bcd_valid<=1, busy<=0,
//             first flag<=0, go IDLE.
//   Latency: capture cycle 0, busy=1 in cycles 1..14, display reg valid in cycle 15.
//   num changes during SHIFT/COMMIT are ignored; IDLE re-compares next cycle, so the latest num
//     is always shown after at most two conversions. num is never sampled outside IDLE.
//   Scan: refresh counter counts 0..REFRESH_DIV-1, wraps; on wrap digit index <= index+1 mod 4.
//     REFRESH_DIV=1: index advances every cycle.
//   Outputs registered: Anode <= ~(4'b0001 << index) when bcd_valid, else 4'b1111;
//     LED_out <= decode(display nibble[index]) when bcd_valid, else 7'b1111111.
//     Anode and LED_out update in the same cycle (no ghosting between digits).
//   Decode: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000
//     7=0001111 8=0000000 9=0000100; nibble >9 unreachable, decodes to 1111111.
//   Reset mid-conversion aborts; after release the first-flag forces a fresh conversion of num.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: digits above the most significant non-zero digit output
//     LED_out=1111111 (anode still scans); value 0 shows single "0" on digit 0 only.
//   Not defined: all four digits always shown with leading zeros (42 -> "0042").
// TESTING
//   1 rst=0 during activity -> same cycle Anode=1111, LED_out=1111111, busy=0, bcd_valid=0.
//   2 REFRESH_DIV=4, release rst, num=42 -> busy=1 cycles 1..14, bcd_valid=1 at 15; scan shows
//     Anode 1110/LED 0010010, 1101/1001100, 1011/0000001, 0111/0000001 (with _EN: last two 1111111).
//   3 num=8191 -> digits units..thousands = 1,9,1,8: LED 1001111,0000100,1001111,0000000.
//   4 num=100, switch to 200 at cycle 5 of conversion -> "0100" committed first, then "0200"
//     committed by cycle 31; busy never glitches low between the two except the one IDLE cycle.
//   5 Anode rotation, REFRESH_DIV=4 -> 1110,1101,1011,0111,1110 each held exactly 4 cycles.
//   6 num=0 stable -> exactly one conversion after reset, busy stays 0 thereafter; with _EN
//     only Anode[0] digit shows 0000001, others 1111111.

Source files
------------

// File: rtl/ssd_scan_controller.sv
// Four-digit seven-segment sequencer: a shift-add-3 FSM converts num to BCD, then the digits are scanned.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module ssd_scan_controller #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] num,
  output logic [3:0]  Anode,
  output logic [6:0]  LED_out,
  output logic        busy,
  output logic        bcd_valid
);

  localparam int unsigned  CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [12:0] shift_q, shift_d;
  logic [12:0] cap_q, cap_d;
  logic [12:0] shown_q, shown_d;
  logic [15:0] scr_q, scr_d;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic [15:0] adj;

  logic [CW-1:0] ref_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q;
  logic [6:0]    led_q;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic          blank;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cap_d   = cap_q;
    shown_d = shown_q;
    scr_d   = scr_q;
    disp_d  = disp_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    first_d = first_q;
    adj     = scr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    unique case (state_q)
      IDLE: begin
        if (first_q || (num != shown_q)) begin
          shift_d = num;
          cap_d   = num;
          scr_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd12) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = scr_q;
        shown_d = cap_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        first_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cap_q   <= '0;
      shown_q <= '0;
      scr_q   <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cap_q   <= cap_d;
      shown_q <= shown_d;
      scr_q   <= scr_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    nib = disp_q[{idx_q, 2'b00} +: 4];
    case (nib)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // a digit is blank when it and every more significant digit are zero; digit 0 always shows
    case (idx_q)
      2'd1:    blank = (disp_q[15:4]  == '0);
      2'd2:    blank = (disp_q[15:8]  == '0);
      2'd3:    blank = (disp_q[15:12] == '0);
      default: blank = 1'b0;
    endcase
`endif
  end

  // Anode and LED_out share one register stage so a digit change never mixes old and new values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      led_q <= '1;
    end else begin
      if (ref_q == LAST) begin
        ref_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        ref_q <= ref_q + CW'(1);
      end
      an_q  <= valid_q ? ~(4'b0001 << idx_q) : 4'b1111;
      led_q <= (valid_q && !blank) ? seg : 7'b1111111;
    end
  end

  assign Anode     = an_q;
  assign LED_out   = led_q;
  assign busy      = busy_q;
  assign bcd_valid = valid_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboard bench for ssd_scan_controller: displayed values are queued when driven, checked on commit.
`timescale 1ns/1ps
module tb_ssd_scan_controller;

  localparam int unsigned RDIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] num = '0;
  logic [3:0]  Anode;
  logic [6:0]  LED_out;
  logic        busy;
  logic        bcd_valid;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [12:0] exp_q[$];

  ssd_scan_controller #(.REFRESH_DIV(RDIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .num      (num),
    .Anode    (Anode),
    .LED_out  (LED_out),
    .busy     (busy),
    .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input int unsigned d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_led(input logic [12:0] v, input int unsigned pos);
    int unsigned div = 1;
    for (int unsigned i = 0; i < pos; i++) div = div * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && int'(v) < int'(div)) return 7'b1111111;
`endif
    return seg_of((int'(v) / div) % 10);
  endfunction

  function automatic int unsigned idx_of(input logic [3:0] oh);
    for (int unsigned i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_anode"}, Anode, 4'b1111);
    check({tag, "_led"},   LED_out, 7'b1111111);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_valid"}, bcd_valid, 1'b0);
  endtask

  task automatic check_latency(input string tag);
    for (int unsigned k = 1; k <= 15; k++) begin
      tick();
      check({tag, "_busy"},  busy, (k <= 14));
      check({tag, "_valid"}, bcd_valid, (k >= 15));
    end
  endtask

  task automatic wait_commit(output int unsigned cycles);
    logic seen = 1'b0;
    cycles = 0;
    while (cycles < 100) begin
      tick();
      cycles++;
      if (seen && !busy) break;
      if (busy) seen = 1'b1;
    end
    check("commit_seen", (seen && !busy), 1'b1);
  endtask

  task automatic pop_expect(output logic [12:0] v);
    check("queue_nonempty", (exp_q.size() != 0), 1'b1);
    v = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
  endtask

  task automatic check_hold(input logic [12:0] v, input int unsigned n);
    logic [3:0] oh;
    logic [6:0] e;
    for (int unsigned i = 0; i < n; i++) begin
      oh = ~Anode;
      e  = exp_led(v, idx_of(oh));
      check("hold_onehot", $countones(oh), 1);
      check("hold_led", LED_out, e);
      tick();
    end
  endtask

  task automatic check_scan(input logic [12:0] v);
    logic [3:0] a, oh, nxt;
    logic [6:0] e;
    int unsigned hold;
    for (int unsigned w = 0; w < 2; w++) begin
      a = Anode;
      hold = 0;
      while (Anode == a && hold < 4 * RDIV + 4) begin tick(); hold++; end
      check("scan_sync", (Anode != a), 1'b1);
    end
    for (int unsigned p = 0; p < 5; p++) begin
      a   = Anode;
      oh  = ~a;
      nxt = ~{oh[2:0], oh[3]};
      e   = exp_led(v, idx_of(oh));
      check("scan_onehot", $countones(oh), 1);
      check("scan_led", LED_out, e);
      hold = 0;
      while (Anode == a && hold < RDIV + 4) begin
        if (hold != 0) check("scan_led_steady", LED_out, e);
        tick();
        hold++;
      end
      check("scan_hold", hold, RDIV);
      check("scan_rotate", Anode, nxt);
    end
  endtask

  task automatic commit_check();
    logic [12:0] v;
    pop_expect(v);
    check_scan(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c, c2, busy_hi;
    logic [12:0] v;

    #2 rst = 1'b0;
    #1 check_reset("rst_init");
    tick();
    tick();
    check_reset("rst_held");

    num = 13'd42;
    exp_q.push_back(13'd42);
    rst = 1'b1;
    check_latency("lat42");
    commit_check();

    num = 13'd8191;
    exp_q.push_back(13'd8191);
    wait_commit(c);
    check("lat8191", c, 15);
    commit_check();

    // value changes mid-conversion: 100 commits first, 200 follows after one IDLE cycle
    num = 13'd100;
    exp_q.push_back(13'd100);
    for (int unsigned i = 0; i < 5; i++) tick();
    num = 13'd200;
    exp_q.push_back(13'd200);
    wait_commit(c);
    check("chg_first_commit", c + 5, 15);
    pop_expect(v);
    tick();
    check("chg_busy_dip", busy, 1'b1);
    check_hold(v, 12);
    wait_commit(c2);
    check("chg_second_commit", 15 + 1 + 12 + c2, 30);
    commit_check();

    num = 13'd1234;
    for (int unsigned i = 0; i < 6; i++) tick();
    check("midconv_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1 check_reset("rst_mid");
    @(posedge clk);
    #1 check_reset("rst_mid_held");

    num = 13'd0;
    exp_q.push_back(13'd0);
    rst = 1'b1;
    check_latency("lat0");
    commit_check();
    busy_hi = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      tick();
      if (busy) busy_hi++;
    end
    check("zero_no_reconvert", busy_hi, 0);
    check("zero_valid_sticky", bcd_valid, 1'b1);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
